reg_file: RTL



---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_register.sv | 37 +++
 rtl/reg_file.sv | 60 ++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the RISC-V general-purpose register file.
// Index 0 is the hardwired-zero register and has no storage.
package reg_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

    // True when a read port must see the data being written in this same cycle.
    function automatic logic bypass_hit(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic [REG_ADDR_W-1:0] raddr
    );
        return we && (waddr != X0_ADDR) && (raddr == waddr);
    endfunction

endpackage

// File: rtl/reg_file_register.sv
// N-bit load-enabled storage register with asynchronous active-high clear.
// One instance backs each architectural register x1..x31.
module register #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] val_d;
    logic [N-1:0] val_q;

    // Next-state: capture d on load, otherwise hold
    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = d;
        end else begin
            val_d = val_q;
        end
    end

    // Storage flop; reset clears immediately and overrides any load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN register file: x0 reads as zero, two combinational read ports,
// one synchronous write port, optional same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    logic [NUM_REGS-1:1] load_s;
    logic [XLEN-1:0]     regs_s [NUM_REGS];

    // x0 has no storage: its mux input is a constant zero
    assign regs_s[0] = '0;

    // Write decoder and storage; decoding from index 1 upward drops x0 writes
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
        assign load_s[i] = we & (waddr == REG_ADDR_W'(i));

        register #(.N(XLEN)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .load (load_s[i]),
            .d    (wdata),
            .q    (regs_s[i])
        );
    end

    // One 32:1 read mux per port, each with its own forwarding check
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [REG_ADDR_W-1:0] addr_s;
        logic [XLEN-1:0]       data_s;

        assign addr_s = (p == 0) ? raddr1 : raddr2;

        // Select stored value, or forward wdata when enabled and hit
        always_comb begin
            data_s = regs_s[addr_s];
            if (BYPASS && bypass_hit(we, waddr, addr_s)) begin
                data_s = wdata;
            end else begin
                data_s = regs_s[addr_s];
            end
        end
    end

    assign rdata1 = g_port[0].data_s;
    assign rdata2 = g_port[1].data_s;

endmodule
